core_fetch_prefetch: RTL and testbench
======================================

# core_fetch_prefetch

Instruction fetch stage of the core: issues word-aligned instruction reads on the instruction bus and buffers returned words with their PC and abort status in a small prefetch FIFO. Sits directly upstream of the control/issue stage and supplies its `insn`, `insn_pc` and `issue_abort` inputs. Handles branch redirects by flushing the FIFO and discarding any stale in-flight response.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `halt`  in  1  suppresses new bus requests; FIFO contents retained.
- `flush`  in  1  redirect; discards FIFO and in-flight data.
- `target`  in  ptr(30)  word address fetched after `flush`.
- `bus_start`  out  1  one-cycle request pulse.
- `bus_addr`  out  ptr(30)  request word address; stable from `bus_start` until `bus_ready`.
- `bus_ready`  in  1  response strobe; ≥1 cycle after `bus_start`.
- `bus_data`  in  word(32)  read data, valid with `bus_ready`.
- `bus_fault`  in  1  bus error, valid with `bus_ready`.
- `insn_valid`  out  1  FIFO head valid.
- `insn_take`  in  1  consumer pops head this cycle (ignored when `!insn_valid`).
- `insn`  out  word  head instruction; 0 when `!insn_valid`.
- `insn_pc`  out  ptr  head word address; 0 when `!insn_valid`.
- `insn_abort`  out  1  head fetched with `bus_fault`; 0 when `!insn_valid`.
- `perf_fetched`, `perf_discarded`  out  32 each  performance counters (see Configuration).

## Operation
- State: `fetch_pc` (next address), `in_flight`, `discard`, FIFO with `count` (0..DEPTH), head/tail pointers.
- Request: `bus_start` asserted when `!in_flight && !discard && !halt && !flush && count + in_flight < DEPTH`; same cycle `bus_addr <= fetch_pc`, `fetch_pc <= fetch_pc + 1`, `in_flight <= 1`. Single outstanding request only.
- `fetch_pc` is 30-bit, wraps 0x3FFFFFFF → 0.
- Response (`bus_ready`): `in_flight <= 0`. If `discard`, data dropped, `discard <= 0`. Otherwise push {`bus_data`, `bus_addr`, `bus_fault`}.
- Fault entries do not stop fetching; abort is taken only if the entry reaches issue.
- Pop: `insn_valid && insn_take` advances head. Push and pop in the same cycle keep `count` unchanged; push into full FIFO cannot occur (request gating).
- Flush (highest priority): FIFO emptied, `fetch_pc <= target`. If `in_flight && !bus_ready` that cycle, `discard <= 1`. `bus_ready` coinciding with `flush` is dropped without setting `discard`. Concurrent pop ignored.
- `halt` during an in-flight request: response still accepted and pushed.
- Reset mid-transaction: all state cleared; a bus response after reset release with `in_flight == 0` is ignored.

## Timing
- Reset values: `bus_start` 0, `bus_addr` 0, `fetch_pc` 0, `in_flight` 0, `discard` 0, `count` 0, `insn_valid` 0, `insn`/`insn_pc`/`insn_abort` 0, perf counters 0.
- `bus_start`, `bus_addr` registered. First request the cycle after reset release (`bus_addr` = 0 visible with pulse).
- `bus_ready` at cycle t → `insn_valid` at t+1 (from empty).
- `flush` at t, idle bus → `bus_start` with `bus_addr = target` at t+1. Flush with stale request in flight → new request the cycle after the stale `bus_ready`.
- Head outputs are combinational from FIFO registers; no path from `insn_take` to `bus_*` within a cycle except request gating via `count`.

## Configuration
- `CORE_FETCH_PERF_EN` defined: `perf_fetched` increments per pushed word, `perf_discarded` per word dropped by flush (FIFO entries cleared plus discarded in-flight response); both wrap at 2^32.
- Undefined: counters not instantiated, both outputs tied to 0.

## Structure
- `core/uarch.sv` package: existing `ptr`, `word`; add `fetch_entry` struct {word insn; ptr pc; logic abort}.
- Sub-module `core_fetch_fifo`: DEPTH-entry circular buffer of `fetch_entry` with push/pop/clear, `count`, head output.

## Test plan
- Reset release, `bus_ready` 2 cycles after each start, data = addr*4, `insn_take` held 1 → words PC 0,1,2,… delivered in order, `insn` = `insn_pc`*4.
- `insn_take` 0, DEPTH 4 → exactly 4 requests, then `bus_start` stays 0; one take → one new request next cycle.
- `flush`, `target` = 0x100 while request to 0x5 in flight → 0x5 response dropped, next `bus_addr` 0x100, FIFO empty until its response.
- `flush` coinciding with `bus_ready` → response dropped, `bus_start` addr = target at t+1, `discard` not set.
- `bus_fault` on PC 0x3 → entry `insn_abort`=1, PC 0x4 still fetched with abort 0.
- `fetch_pc` = 0x3FFFFFFF → next request addr 0; with `CORE_FETCH_PERF_EN`, 3 flushed FIFO entries + 1 in flight → `perf_discarded` += 4.

Source files
------------

// File: rtl/core_fetch_prefetch_pkg.sv
// =============================================================================
// Module : core_fetch_prefetch_pkg
// Brief  : Shared fetch-stage types: word address, data word, prefetch entry.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package core_fetch_prefetch_pkg;

  typedef logic [29:0] ptr;
  typedef logic [31:0] word;

  typedef struct packed {
    word  insn;
    ptr   pc;
    logic abort;
  } fetch_entry;

  // Word addresses wrap modulo 2^30.
  function automatic ptr ptr_next(input ptr p);
    return p + 30'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_fetch_prefetch_fifo.sv
// =============================================================================
// Module : core_fetch_fifo
// Brief  : DEPTH-entry circular buffer of fetch entries; zeroed head when empty.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module core_fetch_fifo
  import core_fetch_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry             push_entry,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output fetch_entry             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry       mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign do_push    = push && !clear;
  assign do_pop     = pop && head_valid && !clear;
  assign head       = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_fetch_prefetch.sv
// =============================================================================
// Module : core_fetch_prefetch
// Brief  : Instruction fetch with single-outstanding bus request, prefetch FIFO
//          and redirect flush. Optional counters under CORE_FETCH_PERF_EN.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module core_fetch_prefetch
  import core_fetch_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        flush,
  input  ptr          target,
  output logic        bus_start,
  output ptr          bus_addr,
  input  logic        bus_ready,
  input  word         bus_data,
  input  logic        bus_fault,
  output logic        insn_valid,
  input  logic        insn_take,
  output word         insn,
  output ptr          insn_pc,
  output logic        insn_abort,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
);

  localparam int CW = $clog2(DEPTH) + 1;

  ptr              fetch_pc;
  logic            in_flight;
  logic            discard;
  logic [CW-1:0]   count;
  logic            req;
  logic            push;
  logic            pop;
  fetch_entry      push_entry;
  fetch_entry      head;

  always_comb begin
    req  = !in_flight && !discard && !halt && !flush &&
           ((count + CW'(in_flight)) < CW'(DEPTH));
    push = in_flight && bus_ready && !discard && !flush;
    pop  = insn_valid && insn_take && !flush;
    push_entry = '{insn: bus_data, pc: bus_addr, abort: bus_fault};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_start <= 1'b0;
      bus_addr  <= '0;
      fetch_pc  <= '0;
      in_flight <= 1'b0;
      discard   <= 1'b0;
    end else begin
      bus_start <= req;
      if (req) begin
        bus_addr  <= fetch_pc;
        fetch_pc  <= ptr_next(fetch_pc);
        in_flight <= 1'b1;
      end
      // A response landing with the flush is dropped outright; otherwise the
      // still-pending response must be swallowed when it arrives.
      if (flush) begin
        fetch_pc  <= target;
        in_flight <= in_flight && !bus_ready;
        discard   <= in_flight && !bus_ready;
      end else if (in_flight && bus_ready) begin
        in_flight <= 1'b0;
        discard   <= 1'b0;
      end
    end
  end

  core_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head_valid (insn_valid),
    .head       (head)
  );

  assign insn       = head.insn;
  assign insn_pc    = head.pc;
  assign insn_abort = head.abort;

`ifdef CORE_FETCH_PERF_EN
  // An already-stale in-flight word was counted at the flush that staled it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(push);
      if (flush) begin
        perf_discarded <= perf_discarded + 32'(count) + 32'(in_flight && !discard);
      end
    end
  end
`else
  assign perf_fetched   = '0;
  assign perf_discarded = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_fetch_prefetch.sv
// =============================================================================
// Module : tb_core_fetch_prefetch
// Brief  : Randomized bus/consumer stimulus with queue-based expected stream.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_core_fetch_prefetch;
  import core_fetch_prefetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        flush = 1'b0;
  ptr          target = '0;
  logic        bus_start;
  ptr          bus_addr;
  logic        bus_ready = 1'b0;
  word         bus_data = '0;
  logic        bus_fault = 1'b0;
  logic        insn_valid;
  logic        insn_take = 1'b0;
  word         insn;
  ptr          insn_pc;
  logic        insn_abort;
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;

  always #5 clk = ~clk;

  core_fetch_prefetch #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .halt           (halt),
    .flush          (flush),
    .target         (target),
    .bus_start      (bus_start),
    .bus_addr       (bus_addr),
    .bus_ready      (bus_ready),
    .bus_data       (bus_data),
    .bus_fault      (bus_fault),
    .insn_valid     (insn_valid),
    .insn_take      (insn_take),
    .insn           (insn),
    .insn_pc        (insn_pc),
    .insn_abort     (insn_abort),
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded)
  );

  int          tests = 0;
  int          fails = 0;
  fetch_entry  exp_q[$];
  fetch_entry  mon_e;
  ptr          exp_pc;
  bit          pending;
  ptr          p_addr;
  int          p_gen;
  int          gen = 0;
  int          cnt;
  bit          prev_halt;
  bit          prev_flush;
  logic [31:0] m_fetched;
  logic [31:0] m_disc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pending    = 1'b0;
    exp_pc     = '0;
    gen++;
    prev_halt  = 1'b0;
    prev_flush = 1'b0;
    m_fetched  = '0;
    m_disc     = '0;
  endtask

  // fmode: 0 none, 1 flush, 2 flush only when a response lands this cycle.
  task automatic step(input int fmode, input ptr tgt, input bit hlt,
                      input int take_pct, output bit flushed);
    bit rdy;
    bit dof;
    bit infl;
    @(posedge clk);
    #2;
`ifdef CORE_FETCH_PERF_EN
    check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
    check("perf_discarded", 64'(perf_discarded), 64'(m_disc));
`else
    check("perf_fetched_tied", 64'(perf_fetched), 64'd0);
    check("perf_discarded_tied", 64'(perf_discarded), 64'd0);
`endif
    rdy = 1'b0;
    if (pending) begin
      if (cnt == 0) rdy = 1'b1;
      else cnt--;
    end
    if (bus_start === 1'b1) begin
      tests++;
      if (pending || prev_halt || prev_flush || exp_q.size() >= DEPTH) begin
        fails++;
        $display("FAIL request_gating: start with pending=%0d halt=%0d flush=%0d queued=%0d, expected no request",
                 pending, prev_halt, prev_flush, exp_q.size());
      end
      check("bus_addr", 64'(bus_addr), 64'(exp_pc));
      if (!pending) begin
        pending = 1'b1;
        p_addr  = bus_addr;
        p_gen   = gen;
        cnt     = $urandom_range(0, 2);
      end
      exp_pc = exp_pc + 30'd1;
    end
    infl = pending;
    dof  = (fmode == 1) || (fmode == 2 && rdy);
    bus_ready = rdy;
    bus_data  = $urandom;
    bus_fault = rdy && ((p_addr == 30'h3) || ($urandom_range(0, 7) == 0));
    if (rdy) begin
      pending = 1'b0;
      if (!dof && p_gen == gen) begin
        exp_q.push_back('{insn: bus_data, pc: p_addr, abort: bus_fault});
        m_fetched = m_fetched + 32'd1;
      end
    end
    if (dof) begin
      m_disc = m_disc + 32'(exp_q.size()) + 32'(infl && p_gen == gen);
      exp_q.delete();
      exp_pc = tgt;
      gen++;
    end
    flush      = dof;
    target     = dof ? tgt : ptr'($urandom);
    halt       = hlt;
    insn_take  = ($urandom_range(0, 99) < take_pct);
    prev_halt  = hlt;
    prev_flush = dof;
    flushed    = dof;
  endtask

  // Monitor: compares every consumed head against the expected stream.
  always @(negedge clk) begin
    if (rst_n) begin
      if (insn_valid !== 1'b1) begin
        check("idle_head_zero", 64'({insn, insn_pc, insn_abort}), 64'd0);
      end else if (insn_take && !flush) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_insn: got pc %h, expected no valid entry", insn_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("insn_head", 64'({insn, insn_pc, insn_abort}), 64'(mon_e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit f;
    int guard;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_start", 64'(bus_start), 64'd0);
    check("rst_bus_addr", 64'(bus_addr), 64'd0);
    check("rst_insn_valid", 64'(insn_valid), 64'd0);
    check("rst_head", 64'({insn, insn_pc, insn_abort}), 64'd0);
    check("rst_perf", 64'({perf_fetched, perf_discarded}), 64'd0);
    rst_n = 1'b1;

    repeat (40) step(0, '0, 1'b0, 100, f);

    repeat (30) step(0, '0, 1'b0, 0, f);
    check("stall_fill", 64'(exp_q.size()), 64'(DEPTH));
    check("stall_bus_idle", 64'(bus_start), 64'd0);
    step(0, '0, 1'b0, 100, f);
    repeat (15) step(0, '0, 1'b0, 0, f);
    check("refill_one", 64'(exp_q.size()), 64'(DEPTH));

    guard = 0;
    do begin
      step(0, '0, 1'b0, 50, f);
      guard++;
    end while (!(pending && cnt > 0) && guard < 50);
    check("inflight_reached", 64'(pending && cnt > 0), 64'd1);
    step(1, 30'h100, 1'b0, 50, f);
    repeat (20) step(0, '0, 1'b0, 50, f);

    guard = 0;
    do begin
      step(2, 30'h200, 1'b0, 50, f);
      guard++;
    end while (!f && guard < 50);
    check("flush_on_ready_reached", 64'(f), 64'd1);
    repeat (10) step(0, '0, 1'b0, 50, f);

    step(1, 30'h3FFFFFFE, 1'b0, 100, f);
    repeat (20) step(0, '0, 1'b0, 100, f);

    repeat (600) step(($urandom_range(0, 49) == 0) ? 1 : 0, ptr'($urandom),
                      ($urandom_range(0, 4) == 0), 60, f);

    guard = 0;
    do begin
      step(0, '0, 1'b0, 100, f);
      guard++;
    end while (!pending && guard < 50);
    check("pre_reset_inflight", 64'(pending), 64'd1);
    rst_n     = 1'b0;
    bus_ready = 1'b0;
    flush     = 1'b0;
    halt      = 1'b0;
    insn_take = 1'b0;
    model_reset();
    @(negedge clk);
    check("midreset_valid", 64'(insn_valid), 64'd0);
    check("midreset_bus_start", 64'(bus_start), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    bus_ready = 1'b1;
    bus_data  = 32'hDEADBEEF;
    repeat (30) step(0, '0, 1'b0, 100, f);

    repeat (25) step(0, '0, 1'b1, 100, f);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(insn_valid), 64'd0);
    check("drain_bus_idle", 64'(pending), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
